// File: rtl/matrix_weight_server_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : matrix_weight_server_if
// Description : Read-request and weight-load bus for matrix_weight_server.
//               master = consumer / weight loader, slave = the server.
//   matrix_enable  read request, held high by the consumer until ready
//   matrix_addr    element address of the first word of the read
//   matrix_data    BANDWIDTH elements, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   matrix_ready   matrix_data valid for the current request
//   load_en        single-element write strobe
//   load_addr      element address of the write
//   load_data      element to write
//   busy           server is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_weight_server_if #(
    parameter int AW         = 12,
    parameter int DATA_WIDTH = 16,
    parameter int BANDWIDTH  = 16
);
    logic                            matrix_enable;
    logic [AW-1:0]                   matrix_addr;
    logic [DATA_WIDTH*BANDWIDTH-1:0] matrix_data;
    logic                            matrix_ready;
    logic                            load_en;
    logic [AW-1:0]                   load_addr;
    logic [DATA_WIDTH-1:0]           load_data;
    logic                            busy;

    modport master (
        output matrix_enable, matrix_addr, load_en, load_addr, load_data,
        input  matrix_data, matrix_ready, busy
    );

    modport slave (
        input  matrix_enable, matrix_addr, load_en, load_addr, load_data,
        output matrix_data, matrix_ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/matrix_weight_server.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : matrix_weight_server
// Description : Weight store of MAX_ROWS*MAX_COLS signed elements that serves
//               BANDWIDTH consecutive elements per read after LATENCY cycles.
//               Elements past the end of storage read as zero (no wrap).
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (storage itself is not reset)
//   bus    matrix_weight_server_if.slave (request, data, load, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_weight_server #(
    parameter int MAX_ROWS   = 64,
    parameter int MAX_COLS   = 64,
    parameter int BANDWIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input wire                    clk,
    input wire                    rst_n,
    matrix_weight_server_if.slave bus
);

    localparam int DEPTH = MAX_ROWS * MAX_COLS;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW:0] c_DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [3:0]  c_LAT_LOAD  = 4'(LATENCY - 1);

    // One-hot state encoding
    localparam logic [2:0] c_ST_IDLE  = 3'b001;
    localparam logic [2:0] c_ST_FETCH = 3'b010;
    localparam logic [2:0] c_ST_VALID = 3'b100;

    logic [2:0]                      r_state;
    logic [2:0]                      w_state_next;
    logic                            w_start;
    logic                            w_capture;
    logic                            w_count;

    logic [AW-1:0]                   r_req_addr;
    logic [3:0]                      r_lat_cnt;
    logic [DATA_WIDTH*BANDWIDTH-1:0] r_data;
    logic                            r_ready;
    logic [DATA_WIDTH*BANDWIDTH-1:0] w_fetch_data;

    logic [DATA_WIDTH-1:0]           r_mem [DEPTH];

    // ------------------------------------------------------------------------
    // Weight storage: no reset; out-of-range writes are dropped.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (bus.load_en && ({1'b0, bus.load_addr} < c_DEPTH_EXT)) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    // Wide read port. Lane addresses are computed one bit wider so that the
    // tail of a read near the top of storage is zero instead of wrapping.
    // Capture is registered on the same edge as any write, so a coinciding
    // write is seen only by later requests.
    generate
        for (genvar gi = 0; gi < BANDWIDTH; gi++) begin : g_lane
            logic [AW:0] w_lane_addr;
            assign w_lane_addr = {1'b0, r_req_addr} + (AW+1)'(gi);
            assign w_fetch_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                (w_lane_addr < c_DEPTH_EXT) ? r_mem[w_lane_addr[AW-1:0]] : '0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_count      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.matrix_enable) begin
                    w_state_next = c_ST_FETCH;
                    w_start      = 1'b1;
                end
            end
            c_ST_FETCH: begin
                // Consumer withdrawing the request wins over completion.
                if (!bus.matrix_enable) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_lat_cnt == 4'd0) begin
                    w_state_next = c_ST_VALID;
                    w_capture    = 1'b1;
                end else begin
                    w_count      = 1'b1;
                end
            end
            c_ST_VALID: begin
                if (!bus.matrix_enable) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request datapath. matrix_addr is only sampled when leaving IDLE, so
    // the consumer may change it freely while the request is in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_addr <= '0;
            r_lat_cnt  <= '0;
            r_data     <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= (w_state_next == c_ST_VALID);
            if (w_start) begin
                r_req_addr <= bus.matrix_addr;
                r_lat_cnt  <= c_LAT_LOAD;
            end
            if (w_count) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            if (w_capture) begin
                r_data <= w_fetch_data;
            end
        end
    end

    assign bus.matrix_data  = r_data;
    assign bus.matrix_ready = r_ready;
    assign bus.busy         = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_matrix_weight_server.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_matrix_weight_server
// Description : Self-checking bench for matrix_weight_server: directed table,
//               hand-written corner sequences, then randomized requests with
//               concurrent writes checked against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_weight_server;

    localparam int MAX_ROWS   = 64;
    localparam int MAX_COLS   = 64;
    localparam int BANDWIDTH  = 16;
    localparam int DATA_WIDTH = 16;
    localparam int LATENCY    = 2;
    localparam int DEPTH      = MAX_ROWS * MAX_COLS;
    localparam int AW         = $clog2(DEPTH);
    localparam int DW         = DATA_WIDTH;
    localparam int BW         = BANDWIDTH;
    localparam int VW         = DW * BW;

    typedef logic [VW-1:0] vec_t;

    typedef struct {
        int            addr;
        int            hold;
        logic [DW-1:0] e_first;
        logic [DW-1:0] e_last;
    } vec_rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    matrix_weight_server_if #(.AW(AW), .DATA_WIDTH(DW), .BANDWIDTH(BW)) bus ();

    matrix_weight_server #(
        .MAX_ROWS  (MAX_ROWS),
        .MAX_COLS  (MAX_COLS),
        .BANDWIDTH (BANDWIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .LATENCY   (LATENCY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [DW-1:0] model_mem [DEPTH];
    int            n_cmp  = 0;
    int            n_fail = 0;

    logic          pend_we   = 1'b0;
    int            pend_addr = 0;
    logic [DW-1:0] pend_data = '0;

    task automatic check(input string name, input vec_t act, input vec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Spec-level read: BW consecutive elements, zero beyond the top.
    function automatic vec_t model_read(input int addr);
        vec_t v;
        v = '0;
        for (int i = 0; i < BW; i++) begin
            if (addr + i < DEPTH) v[i*DW +: DW] = model_mem[addr + i];
        end
        return v;
    endfunction

    // One clock: present the pending write, take the edge, commit the write
    // to the model, then sample 1 ns after the edge.
    task automatic tick();
        bus.load_en   = pend_we;
        bus.load_addr = AW'(pend_addr);
        bus.load_data = pend_data;
        @(posedge clk);
        if (pend_we && pend_addr < DEPTH) model_mem[pend_addr] = pend_data;
        #1;
        pend_we     = 1'b0;
        bus.load_en = 1'b0;
    endtask

    task automatic load_word(input int a, input logic [DW-1:0] d);
        pend_we   = 1'b1;
        pend_addr = a;
        pend_data = d;
        tick();
    endtask

    // Random write confined to the initialised region 0..255, often aimed
    // into the window being read.
    task automatic rand_write(input int addr);
        if ($urandom_range(0, 2) == 0) begin
            pend_we   = 1'b1;
            pend_addr = ($urandom_range(0, 1) == 1 && addr <= 240)
                        ? addr + int'($urandom_range(0, 15))
                        : int'($urandom_range(0, 255));
            pend_data = DW'($urandom);
        end
    endtask

    task automatic do_request(input int addr, input int hold, input bit rnd,
                              input bit col_we, input int col_addr,
                              input logic [DW-1:0] col_data, output vec_t got);
        vec_t exp;
        exp = '0;
        for (int k = 0; k <= LATENCY; k++) begin
            bus.matrix_enable = 1'b1;
            bus.matrix_addr   = (k == 0) ? AW'(addr) : AW'($urandom);
            if (rnd) rand_write(addr);
            if (k == LATENCY) begin
                // Capture sees memory as it stood before this edge's write.
                exp = model_read(addr);
                if (col_we) begin
                    pend_we   = 1'b1;
                    pend_addr = col_addr;
                    pend_data = col_data;
                end
            end
            tick();
            if (k < LATENCY) begin
                check("ready_early", vec_t'(bus.matrix_ready), vec_t'(1'b0));
                check("busy_fetch", vec_t'(bus.busy), vec_t'(1'b1));
            end
        end
        check("ready_on_time", vec_t'(bus.matrix_ready), vec_t'(1'b1));
        check("data_capture", bus.matrix_data, exp);
        got = bus.matrix_data;
        for (int h = 0; h < hold; h++) begin
            bus.matrix_addr = AW'($urandom);
            if (rnd) rand_write(addr);
            tick();
            check("hold_ready", vec_t'(bus.matrix_ready), vec_t'(1'b1));
            check("hold_data", bus.matrix_data, exp);
            check("hold_busy", vec_t'(bus.busy), vec_t'(1'b1));
        end
        bus.matrix_enable = 1'b0;
        tick();
        check("release_ready", vec_t'(bus.matrix_ready), vec_t'(1'b0));
        check("release_busy", vec_t'(bus.busy), vec_t'(1'b0));
        check("release_data_held", bus.matrix_data, exp);
    endtask

    initial begin
        vec_rec_t tbl [4];
        vec_t     got;
        int       ra;

        tbl[0] = '{0,         5, 16'd0,  16'd15};
        tbl[1] = '{16,        1, 16'd16, 16'd31};
        tbl[2] = '{DEPTH - 4, 2, 16'd7,  16'd0};
        tbl[3] = '{8,         0, 16'd8,  16'd23};

        rst_n             = 1'b0;
        bus.matrix_enable = 1'b0;
        bus.matrix_addr   = '0;
        bus.load_en       = 1'b0;
        bus.load_addr     = '0;
        bus.load_data     = '0;
        repeat (3) tick();
        check("reset_ready", vec_t'(bus.matrix_ready), vec_t'(1'b0));
        check("reset_data", bus.matrix_data, '0);
        check("reset_busy", vec_t'(bus.busy), vec_t'(1'b0));
        rst_n = 1'b1;

        // Contents: 0..31 = index, 32..255 random, top four words = 7.
        for (int a = 0; a < 32; a++) load_word(a, DW'(a));
        for (int a = 32; a < 256; a++) load_word(a, DW'($urandom));
        for (int a = DEPTH - 4; a < DEPTH; a++) load_word(a, 16'd7);

        // Directed table: basic read with hold, boundary, plain reads.
        for (int t = 0; t < 4; t++) begin
            do_request(tbl[t].addr, tbl[t].hold, 1'b0, 1'b0, 0, '0, got);
            check("tbl_first", vec_t'(got[0 +: DW]), vec_t'(tbl[t].e_first));
            check("tbl_last", vec_t'(got[(BW-1)*DW +: DW]), vec_t'(tbl[t].e_last));
        end

        // Abort in FETCH: no ready, back to idle, then a clean request at 16.
        bus.matrix_enable = 1'b1;
        bus.matrix_addr   = AW'(40);
        tick();
        check("abort_busy_fetch", vec_t'(bus.busy), vec_t'(1'b1));
        bus.matrix_enable = 1'b0;
        tick();
        check("abort_idle", vec_t'(bus.busy), vec_t'(1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_ready", vec_t'(bus.matrix_ready), vec_t'(1'b0));
        end
        do_request(16, 0, 1'b0, 1'b0, 0, '0, got);
        check("abort_next_e0", vec_t'(got[0 +: DW]), vec_t'(16'd16));
        check("abort_next_e15", vec_t'(got[15*DW +: DW]), vec_t'(16'd31));

        // Write coinciding with capture: old value now, new value next time.
        do_request(0, 0, 1'b0, 1'b1, 3, 16'h7FFF, got);
        check("collision_old", vec_t'(got[3*DW +: DW]), vec_t'(16'd3));
        do_request(0, 0, 1'b0, 1'b0, 0, '0, got);
        check("collision_new", vec_t'(got[3*DW +: DW]), vec_t'(16'h7FFF));

        // Reset during FETCH, then exact latency and intact memory.
        bus.matrix_enable = 1'b1;
        bus.matrix_addr   = AW'(20);
        tick();
        rst_n = 1'b0;
        tick();
        check("midreset_ready", vec_t'(bus.matrix_ready), vec_t'(1'b0));
        check("midreset_data", bus.matrix_data, '0);
        check("midreset_busy", vec_t'(bus.busy), vec_t'(1'b0));
        rst_n             = 1'b1;
        bus.matrix_enable = 1'b0;
        tick();
        do_request(16, 0, 1'b0, 1'b0, 0, '0, got);
        check("postreset_e0", vec_t'(got[0 +: DW]), vec_t'(16'd16));

        // Randomized requests with concurrent writes.
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 4) == 0) ? DEPTH - int'($urandom_range(1, 4))
                                             : int'($urandom_range(0, 240));
            do_request(ra, int'($urandom_range(0, 4)), 1'b1, 1'b0, 0, '0, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
